// File: rtl/cpu_check_pkg.sv
// Shared types and constants for the CPU run checker.
package cpu_check_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_CHECK,
      S_DONE
   } state_e;

   localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;
   localparam int          V0_IDX        = 2;
   localparam logic [31:0] EXIT_CODE     = 32'd10;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cpu_run_checker_if.sv
// Debug taps, table configuration and result signals of the run checker.
interface cpu_run_checker_if #(
   parameter int NUM_CHECKS = 8,
   parameter int NUM_REGS   = 32
);
   localparam int IW = cpu_check_pkg::idx_w(NUM_CHECKS);
   localparam int CW = $clog2(NUM_CHECKS + 1);

   logic          start;
   logic [31:0]   pc_debug;
   logic [31:0]   instr_debug;
   logic [31:0]   regs_debug [0:NUM_REGS-1];
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic          cfg_en;
   logic [4:0]    cfg_reg;
   logic [31:0]   cfg_val;
   logic          busy;
   logic          done;
   logic          pass;
   logic          timeout;
   logic [CW-1:0] fail_count;
   logic [IW-1:0] first_fail_idx;
   logic [31:0]   first_fail_got;
   logic [31:0]   cycles;

   modport slave (
      input  start, pc_debug, instr_debug, regs_debug,
             cfg_we, cfg_idx, cfg_en, cfg_reg, cfg_val,
      output busy, done, pass, timeout, fail_count,
             first_fail_idx, first_fail_got, cycles
   );

   modport master (
      output start, pc_debug, instr_debug, regs_debug,
             cfg_we, cfg_idx, cfg_en, cfg_reg, cfg_val,
      input  busy, done, pass, timeout, fail_count,
             first_fail_idx, first_fail_got, cycles
   );

endinterface

// File: rtl/halt_detector.sv
// Flags program end: exit syscall with v0 == 10, or a PC held for STABLE_CYCLES cycles.
module halt_detector
   import cpu_check_pkg::*;
#(
   parameter int STABLE_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [31:0] pc_debug,
   input  logic [31:0] instr_debug,
   input  logic [31:0] v0,
   output logic        halt
);
   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

   logic [31:0]   prev_pc_q;
   logic [SW-1:0] stab_q, stab_d;
   logic          pc_same;
   logic          exit_hit;
   logic          stable_hit;

   assign pc_same    = (pc_debug == prev_pc_q);
   assign exit_hit   = (instr_debug == SYSCALL_INSTR) && (v0 == EXIT_CODE);
   // stab_q counts equal-PC cycles already seen, so this cycle is the last one
   assign stable_hit = (STABLE_CYCLES != 0) && pc_same && (stab_q == STAB_LAST);
   assign halt       = exit_hit || stable_hit;

   always_comb begin
      stab_d = stab_q;
      if (!pc_same)
         stab_d = '0;
      else if (stab_q != STAB_LAST)
         stab_d = stab_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_pc_q <= '0;
         stab_q    <= '0;
      end else if (clear) begin
         prev_pc_q <= pc_debug;
         stab_q    <= '0;
      end else begin
         prev_pc_q <= pc_debug;
         stab_q    <= stab_d;
      end
   end

endmodule

// File: rtl/cpu_run_checker.sv
// Core-agnostic end-of-program monitor: waits for halt, drains, then walks the
// expected-register table one entry per cycle and reports the outcome.
module cpu_run_checker
   import cpu_check_pkg::*;
#(
   parameter int NUM_CHECKS     = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int STABLE_CYCLES  = 8,
   parameter int DRAIN_CYCLES   = 4,
   parameter int NUM_REGS       = 32
) (
   input  logic              clk,
   input  logic              reset,
   cpu_run_checker_if.slave  bus
);
   localparam int IW = idx_w(NUM_CHECKS);
   localparam int CW = $clog2(NUM_CHECKS + 1);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_e          state_q;
   logic [NUM_CHECKS-1:0] en_q;
   logic [4:0]      reg_q [NUM_CHECKS];
   logic [31:0]     val_q [NUM_CHECKS];
   logic [IW-1:0]   idx_q;
   logic [DW-1:0]   drain_q;
   logic [CW-1:0]   fail_q;
   logic [IW-1:0]   ffi_q;
   logic [31:0]     ffg_q;
   logic [31:0]     cycles_q;
   logic            pass_q;
   logic            timeout_q;

   logic            halt;
   logic            idle_like;
   logic            mismatch;
   logic [31:0]     got;

   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
   assign got       = bus.regs_debug[reg_q[idx_q]];
   assign mismatch  = en_q[idx_q] && (got != val_q[idx_q]);

   halt_detector #(.STABLE_CYCLES(STABLE_CYCLES)) u_halt (
      .clk         (clk),
      .reset       (reset),
      .clear       (idle_like && bus.start),
      .pc_debug    (bus.pc_debug),
      .instr_debug (bus.instr_debug),
      .v0          (bus.regs_debug[V0_IDX]),
      .halt        (halt)
   );

   // Table is frozen while a run is in flight so the check sees a stable target
   always_ff @(posedge clk) begin
      if (reset) begin
         en_q <= '0;
      end else if (bus.cfg_we && idle_like) begin
         en_q[bus.cfg_idx]  <= bus.cfg_en;
         reg_q[bus.cfg_idx] <= bus.cfg_reg;
         val_q[bus.cfg_idx] <= bus.cfg_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         drain_q   <= '0;
         fail_q    <= '0;
         ffi_q     <= '0;
         ffg_q     <= '0;
         cycles_q  <= '0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state_q   <= S_RUN;
                  cycles_q  <= '0;
                  fail_q    <= '0;
                  ffi_q     <= '0;
                  ffg_q     <= '0;
                  pass_q    <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
            S_RUN: begin
               if (cycles_q != '1)
                  cycles_q <= cycles_q + 32'd1;
               // halt takes priority over a coincident timeout
               if (halt) begin
                  if (DRAIN_CYCLES == 0) begin
                     state_q <= S_CHECK;
                     idx_q   <= '0;
                  end else begin
                     state_q <= S_DRAIN;
                     drain_q <= DW'(DRAIN_CYCLES - 1);
                  end
               end else if (cycles_q == 32'(TIMEOUT_CYCLES - 1)) begin
                  state_q   <= S_DONE;
                  timeout_q <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (drain_q == '0) begin
                  state_q <= S_CHECK;
                  idx_q   <= '0;
               end else begin
                  drain_q <= drain_q - 1'b1;
               end
            end
            S_CHECK: begin
               if (mismatch) begin
                  fail_q <= fail_q + 1'b1;
                  if (fail_q == '0) begin
                     ffi_q <= idx_q;
                     ffg_q <= got;
                  end
               end
               if (idx_q == IW'(NUM_CHECKS - 1)) begin
                  state_q <= S_DONE;
                  pass_q  <= (fail_q == '0) && !mismatch;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy           = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_CHECK);
   assign bus.done           = (state_q == S_DONE);
   assign bus.pass           = pass_q;
   assign bus.timeout        = timeout_q;
   assign bus.fail_count     = fail_q;
   assign bus.first_fail_idx = ffi_q;
   assign bus.first_fail_got = ffg_q;
   assign bus.cycles         = cycles_q;

endmodule
